conv2_accum_relu_pool: RTL and testbench
========================================

Name: conv2_accum_relu_pool

Overview:
Downstream stage of the second convolution layer. It consumes three signed partial-sum streams, one per output channel, for each of three input feature maps delivered back-to-back. Each map is 10x10 valid pixels in raster order. The block accumulates the three maps per pixel, adds a per-channel bias, applies ReLU and requantises to 8 bits. It then 2x2 max-pools each channel to 5x5 and feeds the fully-connected stage.

Parameters:
IN_WIDTH, 24, width of signed input partial sums
ACC_WIDTH, 26, internal accumulator width (IN_WIDTH+2, no overflow over 3 maps plus bias)
OUT_WIDTH, 8, unsigned output pixel width
MAP_WIDTH, 10, valid pixels per row/column of each input map (must be even)
NUM_MAPS, 3, input feature maps accumulated per frame
SHIFT, 8, right shift applied after ReLU
BIAS_1 / BIAS_2 / BIAS_3, package constants, signed ACC_WIDTH bias per output channel

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous frame restart, single-cycle pulse
data_in_1/2/3  in  IN_WIDTH signed  channel partial sums for current pixel
data_in_valid  in  1  qualifies data_in_*; may have arbitrary gaps
data_out_1/2/3  out  OUT_WIDTH  pooled channel pixels
data_out_valid  out  1  one-cycle strobe per pooled pixel
frame_done  out  1  pulses coincident with the 25th data_out_valid of a frame

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset: all outputs 0; pixel counter px, map counter m, pool hold and row buffers 0. The accumulator array is not reset.
- Counters:
  - px runs 0..MAP_WIDTH^2-1 and advances on data_in_valid.
  - At px wrap, m advances 0..NUM_MAPS-1, then wraps to 0 for the next frame with no idle cycles needed.
  - Row r = px / MAP_WIDTH, col c = px % MAP_WIDTH, implemented as separate row and column counters.
- Accumulation, cycle T (input sampled):
  - Map 0: acc[px][ch] <= sign-extended input.
  - Maps 1 to NUM_MAPS-2: acc[px][ch] <= acc[px][ch] + input.
  - Last map: s[ch] <= acc + input + BIAS_ch, registered at T+1.
- Quantisation at T+2: q = (s<0) ? 0 : s>>>SHIFT, saturated to 2^OUT_WIDTH-1.
- Pooling, driven by the delayed row/col of each last-map pixel:
  - Even c: hold[ch] <= q.
  - Odd c: pm = max(hold, q).
  - Even r: rowbuf[c/2][ch] <= pm.
  - Odd r: data_out <= max(rowbuf[c/2], pm), data_out_valid high at T+3, where T is the sample cycle of the odd-row/odd-col pixel.
- Output hold: data_out_* hold their last value between strobes. frame_done pulses with pooled pixel (4,4).
- Latency: fixed 3 cycles. Input gaps stretch the schedule but never alter values or latency.
- clear: has priority over a coincident data_in_valid, and that pixel is discarded. It zeroes px, m and pool state next cycle. In-flight T+1..T+3 pipeline results still emerge.
- Reset mid-frame: all state is lost and the next accepted pixel is map 0, px 0.
- Simultaneous events: a last-map pixel with a pipeline output in flight is legal every cycle. Back-to-back frames overlap cleanly because acc writes go to distinct addresses.

Decomposition:
- Package conv2_pkg holds ACC_WIDTH, MAP_WIDTH, NUM_MAPS, the default bias constants C2_BIAS_1..3 and the pooled map size localparam (MAP_WIDTH/2).
- One sub-module: conv2_relu_quant. It is per-channel, combinational, covering ReLU, shift and saturate, and is instantiated three times. Everything else stays in the top.

Test Plan:
1. BIAS=0, SHIFT=8, all inputs 256 for all 3 maps -> 25 strobes per channel, each value 3; frame_done on the 25th.
2. BIAS=0, all inputs -1000 -> 25 strobes, all outputs 0 (ReLU).
3. BIAS=0, inputs 100000 -> 300000>>8=1171 -> all outputs 255 (saturation).
4. Maps 0 and 1 all zero; map 2 pixel (r,c) = (10r+c)*256; BIAS=0 -> outputs in order 11,13,15,17,19,31,...,99; data_out_valid exactly 3 cycles after each odd/odd input.
5. Random valid gaps across two consecutive frames, default biases -> both frames match the reference model bit-exactly; same 3-cycle latency.
6. Assert rst_n low mid map 1, then clear asserted together with data_in_valid. A subsequent clean frame with test-1 stimulus -> outputs all 3; the discarded pixel is not counted.

Source files
------------

// File: rtl/conv2_pkg.sv
`default_nettype none
// ============================================================================
// Package  : conv2_pkg
// Purpose  : Shared widths, geometry and per-channel bias constants for the
//            conv2 accumulate / ReLU / pool stage.
// Revision : 1.0
// ============================================================================
package conv2_pkg;

   localparam int C2_IN_WIDTH   = 24;
   localparam int C2_ACC_WIDTH  = 26;
   localparam int C2_OUT_WIDTH  = 8;
   localparam int C2_MAP_WIDTH  = 10;
   localparam int C2_NUM_MAPS   = 3;
   localparam int C2_SHIFT      = 8;
   localparam int C2_POOL_WIDTH = C2_MAP_WIDTH / 2;

   // Trained biases, already scaled to the accumulator's fixed-point format
   localparam logic signed [C2_ACC_WIDTH-1:0] C2_BIAS_1 = 26'sd1280;
   localparam logic signed [C2_ACC_WIDTH-1:0] C2_BIAS_2 = -26'sd2560;
   localparam logic signed [C2_ACC_WIDTH-1:0] C2_BIAS_3 = 26'sd100;

endpackage
`default_nettype wire

// File: rtl/conv2_relu_quant.sv
`default_nettype none
// ============================================================================
// Module   : conv2_relu_quant
// Purpose  : One channel of ReLU, arithmetic right shift and unsigned saturate.
// Revision : 1.0
// ============================================================================
module conv2_relu_quant
   import conv2_pkg::*;
#(
   parameter int ACC_WIDTH = C2_ACC_WIDTH,
   parameter int OUT_WIDTH = C2_OUT_WIDTH,
   parameter int SHIFT     = C2_SHIFT
) (
   input  logic [ACC_WIDTH-1:0] i_sum,
   output logic [OUT_WIDTH-1:0] o_pix
);

   logic signed [ACC_WIDTH-1:0] shifted;

   always_comb begin
      shifted = $signed(i_sum) >>> SHIFT;
      if (i_sum[ACC_WIDTH-1]) begin
         o_pix = '0;
      end else if (|shifted[ACC_WIDTH-1:OUT_WIDTH]) begin
         o_pix = '1;
      end else begin
         o_pix = shifted[OUT_WIDTH-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv2_accum_relu_pool.sv
`default_nettype none
// ============================================================================
// Module   : conv2_accum_relu_pool
// Purpose  : Sums NUM_MAPS partial-sum maps per pixel, adds bias, ReLU and
//            requantises, then 2x2 max-pools three channels.
// Revision : 1.0
// ============================================================================
module conv2_accum_relu_pool
   import conv2_pkg::*;
#(
   parameter int IN_WIDTH  = C2_IN_WIDTH,
   parameter int ACC_WIDTH = C2_ACC_WIDTH,
   parameter int OUT_WIDTH = C2_OUT_WIDTH,
   parameter int MAP_WIDTH = C2_MAP_WIDTH,
   parameter int NUM_MAPS  = C2_NUM_MAPS,
   parameter int SHIFT     = C2_SHIFT,
   parameter logic signed [ACC_WIDTH-1:0] BIAS_1 = C2_BIAS_1,
   parameter logic signed [ACC_WIDTH-1:0] BIAS_2 = C2_BIAS_2,
   parameter logic signed [ACC_WIDTH-1:0] BIAS_3 = C2_BIAS_3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic [IN_WIDTH-1:0]  data_in_1,
   input  logic [IN_WIDTH-1:0]  data_in_2,
   input  logic [IN_WIDTH-1:0]  data_in_3,
   input  logic                 data_in_valid,
   output logic [OUT_WIDTH-1:0] data_out_1,
   output logic [OUT_WIDTH-1:0] data_out_2,
   output logic [OUT_WIDTH-1:0] data_out_3,
   output logic                 data_out_valid,
   output logic                 frame_done
);

   localparam int NCH = 3;
   localparam int NPX = MAP_WIDTH * MAP_WIDTH;
   localparam int RCW = $clog2(MAP_WIDTH);
   localparam int MW  = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
   localparam int AW  = $clog2(NPX);
   localparam int PW  = MAP_WIDTH / 2;
   localparam logic [RCW-1:0] LAST_RC = RCW'(MAP_WIDTH - 1);
   localparam logic [MW-1:0]  LAST_M  = MW'(NUM_MAPS - 1);

   // Frame position
   logic [RCW-1:0] row_q, row_d, col_q, col_d;
   logic [MW-1:0]  m_q, m_d;
   logic [AW-1:0]  px;
   logic           take, last_map;

   // Accumulator store and first pipeline stage
   logic signed [ACC_WIDTH-1:0] acc_q   [NPX][NCH];
   logic signed [ACC_WIDTH-1:0] acc_wr  [NCH];
   logic signed [ACC_WIDTH-1:0] in_ext  [NCH];
   logic signed [ACC_WIDTH-1:0] bias    [NCH];
   logic                        acc_we;
   logic        [ACC_WIDTH-1:0] s_q     [NCH];
   logic        [ACC_WIDTH-1:0] s_d     [NCH];
   logic                        s_vld_q, s_vld_d;
   logic        [RCW-1:0]       s_row_q, s_col_q;

   // Quantised stage
   logic [OUT_WIDTH-1:0] q_q [NCH];
   logic [OUT_WIDTH-1:0] q_d [NCH];
   logic                 q_vld_q;
   logic [RCW-1:0]       q_row_q, q_col_q;

   // Pooling state and outputs
   logic [OUT_WIDTH-1:0] hold_q   [NCH];
   logic [OUT_WIDTH-1:0] hold_d   [NCH];
   logic [OUT_WIDTH-1:0] rowbuf_q [PW][NCH];
   logic [OUT_WIDTH-1:0] rowbuf_d [PW][NCH];
   logic [OUT_WIDTH-1:0] pm       [NCH];
   logic [OUT_WIDTH-1:0] pooled   [NCH];
   logic [OUT_WIDTH-1:0] dout_q   [NCH];
   logic [OUT_WIDTH-1:0] dout_d   [NCH];
   logic                 dout_vld_q, dout_vld_d;
   logic                 done_q, done_d;
   logic [RCW-2:0]       pidx;

   assign in_ext[0] = ACC_WIDTH'($signed(data_in_1));
   assign in_ext[1] = ACC_WIDTH'($signed(data_in_2));
   assign in_ext[2] = ACC_WIDTH'($signed(data_in_3));
   assign bias[0]   = BIAS_1;
   assign bias[1]   = BIAS_2;
   assign bias[2]   = BIAS_3;

   assign take     = data_in_valid & ~clear;
   assign last_map = (m_q == LAST_M);
   assign px       = AW'(row_q * MAP_WIDTH + col_q);
   assign pidx     = q_col_q[RCW-1:1];

   generate
      for (genvar g = 0; g < NCH; g++) begin : g_ch
         conv2_relu_quant #(
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .SHIFT     (SHIFT)
         ) u_quant (
            .i_sum (s_q[g]),
            .o_pix (q_d[g])
         );
      end
   endgenerate

   always_comb begin
      row_d      = row_q;
      col_d      = col_q;
      m_d        = m_q;
      hold_d     = hold_q;
      rowbuf_d   = rowbuf_q;
      dout_d     = dout_q;
      dout_vld_d = 1'b0;
      done_d     = 1'b0;
      acc_we     = take & ~last_map;
      s_vld_d    = take & last_map;

      for (int ch = 0; ch < NCH; ch++) begin
         acc_wr[ch] = (m_q == '0) ? in_ext[ch] : acc_q[px][ch] + in_ext[ch];
         s_d[ch]    = acc_q[px][ch] + in_ext[ch] + bias[ch];
         pm[ch]     = (q_q[ch] > hold_q[ch]) ? q_q[ch] : hold_q[ch];
         pooled[ch] = (rowbuf_q[pidx][ch] > pm[ch]) ? rowbuf_q[pidx][ch] : pm[ch];
      end

      if (clear) begin
         row_d = '0;
         col_d = '0;
         m_d   = '0;
      end else if (data_in_valid) begin
         if (col_q == LAST_RC) begin
            col_d = '0;
            if (row_q == LAST_RC) begin
               row_d = '0;
               m_d   = last_map ? '0 : m_q + 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      // Even column parks its value; odd column pairs it, odd row finishes the 2x2
      if (q_vld_q) begin
         if (!q_col_q[0]) begin
            hold_d = q_q;
         end else if (!q_row_q[0]) begin
            rowbuf_d[pidx] = pm;
         end else begin
            dout_d     = pooled;
            dout_vld_d = 1'b1;
            done_d     = (q_row_q == LAST_RC) && (q_col_q == LAST_RC);
         end
      end

      if (clear) begin
         for (int ch = 0; ch < NCH; ch++) begin
            hold_d[ch] = '0;
            for (int p = 0; p < PW; p++) begin
               rowbuf_d[p][ch] = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q      <= '0;
         col_q      <= '0;
         m_q        <= '0;
         s_vld_q    <= 1'b0;
         s_row_q    <= '0;
         s_col_q    <= '0;
         q_vld_q    <= 1'b0;
         q_row_q    <= '0;
         q_col_q    <= '0;
         dout_vld_q <= 1'b0;
         done_q     <= 1'b0;
         for (int ch = 0; ch < NCH; ch++) begin
            s_q[ch]    <= '0;
            q_q[ch]    <= '0;
            hold_q[ch] <= '0;
            dout_q[ch] <= '0;
            for (int p = 0; p < PW; p++) begin
               rowbuf_q[p][ch] <= '0;
            end
         end
      end else begin
         row_q      <= row_d;
         col_q      <= col_d;
         m_q        <= m_d;
         s_q        <= s_d;
         s_vld_q    <= s_vld_d;
         s_row_q    <= row_q;
         s_col_q    <= col_q;
         q_q        <= q_d;
         q_vld_q    <= s_vld_q;
         q_row_q    <= s_row_q;
         q_col_q    <= s_col_q;
         hold_q     <= hold_d;
         rowbuf_q   <= rowbuf_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         done_q     <= done_d;
      end
   end

   // Accumulator contents are always rewritten by map 0, so no reset is needed
   always_ff @(posedge clk) begin
      if (acc_we) begin
         for (int ch = 0; ch < NCH; ch++) begin
            acc_q[px][ch] <= acc_wr[ch];
         end
      end
   end

   assign data_out_1     = dout_q[0];
   assign data_out_2     = dout_q[1];
   assign data_out_3     = dout_q[2];
   assign data_out_valid = dout_vld_q;
   assign frame_done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv2_accum_relu_pool.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv2_accum_relu_pool
// Purpose  : Directed bench; a zero-bias and a default-bias instance share one
//            stimulus and are compared against a whole-frame reference model.
// Revision : 1.0
// ============================================================================
module tb_conv2_accum_relu_pool;
   import conv2_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        valid = 1'b0;
   logic [23:0] din1 = '0, din2 = '0, din3 = '0;
   logic [7:0]  a1, a2, a3, b1, b2, b3;
   logic        av, bv, ad, bd;

   always #5 clk = ~clk;

   conv2_accum_relu_pool #(
      .BIAS_1 (26'sd0),
      .BIAS_2 (26'sd0),
      .BIAS_3 (26'sd0)
   ) dut0 (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear          (clear),
      .data_in_1      (din1),
      .data_in_2      (din2),
      .data_in_3      (din3),
      .data_in_valid  (valid),
      .data_out_1     (a1),
      .data_out_2     (a2),
      .data_out_3     (a3),
      .data_out_valid (av),
      .frame_done     (ad)
   );

   conv2_accum_relu_pool dut1 (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear          (clear),
      .data_in_1      (din1),
      .data_in_2      (din2),
      .data_in_3      (din3),
      .data_in_valid  (valid),
      .data_out_1     (b1),
      .data_out_2     (b2),
      .data_out_3     (b3),
      .data_out_valid (bv),
      .frame_done     (bd)
   );

   typedef struct {
      int          due;
      logic [23:0] v0;
      logic [23:0] v1;
      logic        done;
   } exp_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   logic        chk_en = 1'b0;
   exp_t        eq[$];
   logic [23:0] cap[$];
   logic [23:0] last0 = '0, last1 = '0;
   int          mdl [10][10][3];
   int          bset [2][3];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, req, $time);
      end
   endtask

   function automatic int qz(input int s);
      if (s < 0) return 0;
      if (s / 256 > 255) return 255;
      return s / 256;
   endfunction

   // Max of the four requantised pixels whose bottom-right corner is (r,c)
   function automatic logic [7:0] pool(input int r, input int c, input int ch, input int b);
      int best = 0;
      for (int dr = 0; dr < 2; dr++)
         for (int dc = 0; dc < 2; dc++)
            if (qz(mdl[r-dr][c-dc][ch] + b) > best) best = qz(mdl[r-dr][c-dc][ch] + b);
      return 8'(best);
   endfunction

   always @(negedge clk) begin
      logic due;
      if (chk_en) begin
         due = (eq.size() > 0) && (eq[0].due == cyc);
         chk("valid0", int'(av), int'(due));
         chk("valid1", int'(bv), int'(due));
         if (av) cap.push_back({a1, a2, a3});
         if (ad) done_cnt++;
         if (due) begin
            chk("out0", int'({a1, a2, a3}), int'(eq[0].v0));
            chk("out1", int'({b1, b2, b3}), int'(eq[0].v1));
            chk("done0", int'(ad), int'(eq[0].done));
            chk("done1", int'(bd), int'(eq[0].done));
            last0 = eq[0].v0;
            last1 = eq[0].v1;
            void'(eq.pop_front());
         end else begin
            chk("hold0", int'({a1, a2, a3}), int'(last0));
            chk("hold1", int'({b1, b2, b3}), int'(last1));
            chk("nodone0", int'(ad), 0);
            chk("nodone1", int'(bd), 0);
         end
      end
   end

   task automatic idle();
      valid = 1'b0;
      din1  = 24'($urandom);
      din2  = 24'($urandom);
      din3  = 24'($urandom);
      @(posedge clk);
      #1;
   endtask

   task automatic send_px(input int m, input int r, input int c, input int v1, input int v2, input int v3);
      int   v[3];
      exp_t e;
      v[0] = v1; v[1] = v2; v[2] = v3;
      din1  = 24'(v1);
      din2  = 24'(v2);
      din3  = 24'(v3);
      valid = 1'b1;
      for (int ch = 0; ch < 3; ch++)
         mdl[r][c][ch] = (m == 0) ? v[ch] : mdl[r][c][ch] + v[ch];
      if (m == 2 && (r % 2) == 1 && (c % 2) == 1) begin
         e.due  = cyc + 3;
         e.done = (r == 9 && c == 9);
         e.v0   = {pool(r, c, 0, bset[0][0]), pool(r, c, 1, bset[0][1]), pool(r, c, 2, bset[0][2])};
         e.v1   = {pool(r, c, 0, bset[1][0]), pool(r, c, 1, bset[1][1]), pool(r, c, 2, bset[1][2])};
         eq.push_back(e);
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   // kind 0: constant; 1: ramp on map 2 only; 2: random per channel
   task automatic send_frame(input int kind, input int base, input int gap, input int limit);
      int n = 0;
      int v1, v2, v3;
      for (int m = 0; m < 3; m++)
         for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) begin
               if (limit >= 0 && n == limit) return;
               case (kind)
                  0: begin v1 = base; v2 = base; v3 = base; end
                  1: begin
                     v1 = (m == 2) ? (10 * r + c) * 256 : 0;
                     v2 = v1;
                     v3 = v1;
                  end
                  default: begin
                     v1 = int'($urandom_range(0, 40000)) - 8000;
                     v2 = int'($urandom_range(0, 40000)) - 8000;
                     v3 = int'($urandom_range(0, 40000)) - 8000;
                  end
               endcase
               send_px(m, r, c, v1, v2, v3);
               n++;
               if (gap > 0) repeat ($urandom_range(0, gap)) idle();
            end
   endtask

   task automatic drain();
      repeat (6) idle();
      chk("drain", eq.size(), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid = 1'b0;
      clear = 1'b0;
      eq.delete();
      last0 = '0;
      last1 = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic start_test();
      cap.delete();
      done_cnt = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired time=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bset[0][0] = 0; bset[0][1] = 0; bset[0][2] = 0;
      bset[1][0] = C2_BIAS_1; bset[1][1] = C2_BIAS_2; bset[1][2] = C2_BIAS_3;
      do_reset();
      chk_en = 1'b1;
      chk("reset_valid", int'(av), 0);
      chk("reset_out", int'({a1, a2, a3}), 0);
      chk("reset_done", int'(ad), 0);

      // Plain accumulate: 3*256 >> 8 = 3
      start_test();
      send_frame(0, 256, 0, -1);
      drain();
      chk("t1_count", cap.size(), 25);
      chk("t1_first", int'(cap[0]), 24'h030303);
      chk("t1_last", int'(cap[24]), 24'h030303);
      chk("t1_done", done_cnt, 1);

      // ReLU clamps negatives
      start_test();
      send_frame(0, -1000, 0, -1);
      drain();
      chk("t2_count", cap.size(), 25);
      chk("t2_first", int'(cap[0]), 0);
      chk("t2_mid", int'(cap[12]), 0);
      chk("t2_done", done_cnt, 1);

      // Saturation: 300000 >> 8 = 1171
      start_test();
      send_frame(0, 100000, 0, -1);
      drain();
      chk("t3_count", cap.size(), 25);
      chk("t3_first", int'(cap[0]), 24'hffffff);
      chk("t3_last", int'(cap[24]), 24'hffffff);

      // Ramp picks the bottom-right pixel of every window
      start_test();
      send_frame(1, 0, 0, -1);
      drain();
      chk("t4_count", cap.size(), 25);
      chk("t4_p0", int'(cap[0]), 24'h0b0b0b);
      chk("t4_p1", int'(cap[1]), 24'h0d0d0d);
      chk("t4_p4", int'(cap[4]), 24'h131313);
      chk("t4_p5", int'(cap[5]), 24'h1f1f1f);
      chk("t4_p24", int'(cap[24]), 24'h636363);
      chk("t4_done", done_cnt, 1);

      // Two back-to-back random frames with input gaps
      start_test();
      send_frame(2, 0, 3, -1);
      send_frame(2, 0, 3, -1);
      drain();
      chk("t5_count", cap.size(), 50);
      chk("t5_done", done_cnt, 2);

      // Reset mid map 1, partial map 0, then clear with a coincident pixel
      send_frame(0, 256, 0, 150);
      do_reset();
      chk("t6_reset_out", int'({a1, a2, a3}), 0);
      send_frame(0, 777, 0, 7);
      clear = 1'b1;
      valid = 1'b1;
      din1  = 24'd5000000;
      din2  = 24'd5000000;
      din3  = 24'd5000000;
      @(posedge clk);
      #1;
      clear = 1'b0;
      valid = 1'b0;
      start_test();
      send_frame(0, 256, 0, -1);
      drain();
      chk("t6_count", cap.size(), 25);
      chk("t6_first", int'(cap[0]), 24'h030303);
      chk("t6_last", int'(cap[24]), 24'h030303);
      chk("t6_done", done_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
